// File: rtl/adder_ext_responder_if.sv
// Request/response bus for adder_ext_responder.
//   master : requester/consumer side (drives req_valid, req_foo, resp_ready)
//   slave  : responder side (drives req_ready, resp_valid, resp_bar,
//            resp_count, busy)
interface adder_ext_responder_if #(
  parameter int unsigned WIDTH = 16
);

  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_foo;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_bar;
  logic [7:0]       resp_count;
  logic             busy;

  modport master (
    output req_valid, req_foo, resp_ready,
    input  req_ready, resp_valid, resp_bar, resp_count, busy
  );

  modport slave (
    input  req_valid, req_foo, resp_ready,
    output req_ready, resp_valid, resp_bar, resp_count, busy
  );

endinterface

// File: rtl/adder_ext_responder.sv
// Credit-flow incrementer: each accepted operand travels a fixed LATENCY
// pipeline, lands in a DEPTH-entry result queue and is returned as
// operand + INC. Admission is limited by credits so the queue never overflows
// and the pipeline never stalls.
//   clock : sole clock, rising edge
//   reset : asynchronous, active-low
//   bus   : adder_ext_responder_if.slave (request, response, status)
module adder_ext_responder #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned INC     = 1,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned DEPTH   = 4
) (
  input logic                  clock,
  input logic                  reset,
  adder_ext_responder_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [LATENCY-1:0] pipe_vld_q;
  logic [WIDTH-1:0]   pipe_dat_q [LATENCY];
  logic [WIDTH-1:0]   mem_q      [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] out_q, out_d;

  logic             req_ready_q;
  logic             resp_valid_q;
  logic             busy_q;
  logic [WIDTH-1:0] resp_bar_q, resp_bar_d;
  logic [7:0]       resp_count_q;

  logic             accept_c;
  logic             pop_c;
  logic             push_c;
  logic [WIDTH-1:0] push_dat_c;

  // Handshake decode and next-state for pointers, occupancy and credits.
  always_comb begin
    accept_c   = bus.req_valid & req_ready_q;
    pop_c      = resp_valid_q & bus.resp_ready;
    push_c     = pipe_vld_q[LATENCY-1];
    push_dat_c = pipe_dat_q[LATENCY-1];

    wr_ptr_d = wr_ptr_q + PTR_W'(push_c);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_c);
    occ_d    = occ_q + CNT_W'(push_c) - CNT_W'(pop_c);
    out_d    = out_q + CNT_W'(accept_c) - CNT_W'(pop_c);

    // Head after this edge; the entry being written this edge is not yet
    // visible in mem_q, so forward it when it becomes the new head.
    resp_bar_d = resp_bar_q;
    if (occ_d != '0) begin
      if (push_c && (wr_ptr_q == rd_ptr_d)) begin
        resp_bar_d = push_dat_c;
      end else begin
        resp_bar_d = mem_q[rd_ptr_d];
      end
    end
  end

  // Result storage; contents are qualified by occupancy, so no reset needed.
  always_ff @(posedge clock) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= push_dat_c;
    end
  end

  // Pipeline, queue control and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pipe_vld_q <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        pipe_dat_q[i] <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      out_q        <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      resp_bar_q   <= '0;
      resp_count_q <= '0;
    end else begin
      pipe_vld_q[0] <= accept_c;
      pipe_dat_q[0] <= bus.req_foo + WIDTH'(INC);
      for (int unsigned i = 1; i < LATENCY; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_dat_q[i] <= pipe_dat_q[i-1];
      end
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      out_q        <= out_d;
      // Status outputs are registered images of the post-edge counters.
      req_ready_q  <= (out_d < CNT_W'(DEPTH));
      resp_valid_q <= (occ_d != '0);
      busy_q       <= (out_d != '0);
      resp_bar_q   <= resp_bar_d;
      resp_count_q <= resp_count_q + 8'(pop_c);
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_bar   = resp_bar_q;
  assign bus.resp_count = resp_count_q;
  assign bus.busy       = busy_q;

endmodule
